// File: rtl/fetch_ctrl.sv
//==============================================================================
// Module   : fetch_ctrl
// Purpose  : Next-PC select and F/D/E/M stall/flush control (exceptions, eret,
//            hazards, mult/div busy). Optional macro: FETCH_CTRL_MD_STALL_EN.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module fetch_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic       exc_req,
    input  logic       eret_D,
    input  logic       epc_wr_pend,
    input  logic       haz_stall,
    input  logic       br_D,
    input  logic       jal_D,
    input  logic       jr_D,
    input  logic       j_D,
    input  logic       md_start,
    input  logic       md_is_div,
    input  logic       md_use_D,
    output logic       npc_en,
    output logic       npc_req,
    output logic [2:0] npc_op,
    output logic       stall_FD,
    output logic       flush_E,
    output logic       flush_all,
    output logic       md_busy,
    output logic       exc_ack,
    output logic [1:0] state
);

    localparam logic [2:0] NPC_OTHER  = 3'd0;
    localparam logic [2:0] NPC_BRANCH = 3'd1;
    localparam logic [2:0] NPC_JAL    = 3'd2;
    localparam logic [2:0] NPC_JR     = 3'd3;
    localparam logic [2:0] NPC_J      = 3'd4;
    localparam logic [2:0] NPC_EPC    = 3'd5;

    typedef enum logic [1:0] {
        S_RUN       = 2'd0,
        S_HAZ       = 2'd1,
        S_ERET_WAIT = 2'd2,
        S_EXC       = 2'd3
    } state_t;

    state_t state_q, state_d;
    logic   exc_ack_q;
    logic   w_stall;

`ifdef FETCH_CTRL_MD_STALL_EN
    logic [3:0] md_cnt_q, md_cnt_d;

    // A new op is accepted only when idle and not being killed by an exception.
    always_comb begin
        md_cnt_d = md_cnt_q;
        if (md_cnt_q != 4'd0)
            md_cnt_d = md_cnt_q - 4'd1;
        else if (md_start && !exc_req)
            md_cnt_d = md_is_div ? 4'd10 : 4'd5;
    end

    always_ff @(posedge clk) begin
        if (reset)
            md_cnt_q <= 4'd0;
        else
            md_cnt_q <= md_cnt_d;
    end

    assign md_busy = (md_cnt_q != 4'd0);
`else
    logic w_md_unused;
    assign w_md_unused = md_start ^ md_is_div;
    assign md_busy     = 1'b0;
`endif

    assign w_stall = haz_stall || (md_use_D && md_busy);

    always_comb begin
        npc_en    = 1'b1;
        npc_req   = 1'b0;
        npc_op    = NPC_OTHER;
        stall_FD  = 1'b0;
        flush_E   = 1'b0;
        flush_all = 1'b0;
        state_d   = state_q;
        if (reset) begin
            state_d = S_RUN;
        end else if (state_q == S_EXC) begin
            state_d = S_RUN;
        end else if (exc_req) begin
            npc_req   = 1'b1;
            flush_all = 1'b1;
            state_d   = S_EXC;
        end else if (state_q == S_ERET_WAIT) begin
            if (epc_wr_pend) begin
                npc_en   = 1'b0;
                stall_FD = 1'b1;
                flush_E  = 1'b1;
            end else begin
                npc_op  = NPC_EPC;
                state_d = S_RUN;
            end
        end else if (eret_D && epc_wr_pend) begin
            npc_en   = 1'b0;
            stall_FD = 1'b1;
            flush_E  = 1'b1;
            state_d  = S_ERET_WAIT;
        end else if (eret_D) begin
            npc_op  = NPC_EPC;
            state_d = S_RUN;
        end else if (w_stall) begin
            npc_en   = 1'b0;
            stall_FD = 1'b1;
            flush_E  = 1'b1;
            state_d  = S_HAZ;
        end else begin
            // Leaving HAZ honours the D-stage decode in the same cycle.
            state_d = S_RUN;
            if (jr_D)
                npc_op = NPC_JR;
            else if (jal_D)
                npc_op = NPC_JAL;
            else if (j_D)
                npc_op = NPC_J;
            else if (br_D)
                npc_op = NPC_BRANCH;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_RUN;
            exc_ack_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            exc_ack_q <= (state_d == S_EXC);
        end
    end

    assign state   = state_q;
    assign exc_ack = exc_ack_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
//==============================================================================
// Module   : tb_fetch_ctrl
// Purpose  : Directed-vector scoreboard bench for fetch_ctrl.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_fetch_ctrl;

    logic       clk = 1'b0;
    logic       reset, exc_req, eret_D, epc_wr_pend, haz_stall;
    logic       br_D, jal_D, jr_D, j_D, md_start, md_is_div, md_use_D;
    logic       npc_en, npc_req, stall_FD, flush_E, flush_all, md_busy, exc_ack;
    logic [2:0] npc_op;
    logic [1:0] state;

    fetch_ctrl u_dut (
        .clk        (clk),
        .reset      (reset),
        .exc_req    (exc_req),
        .eret_D     (eret_D),
        .epc_wr_pend(epc_wr_pend),
        .haz_stall  (haz_stall),
        .br_D       (br_D),
        .jal_D      (jal_D),
        .jr_D       (jr_D),
        .j_D        (j_D),
        .md_start   (md_start),
        .md_is_div  (md_is_div),
        .md_use_D   (md_use_D),
        .npc_en     (npc_en),
        .npc_req    (npc_req),
        .npc_op     (npc_op),
        .stall_FD   (stall_FD),
        .flush_E    (flush_E),
        .flush_all  (flush_all),
        .md_busy    (md_busy),
        .exc_ack    (exc_ack),
        .state      (state)
    );

    always #5 clk = ~clk;

    localparam logic [11:0] R   = 12'h800;
    localparam logic [11:0] EX  = 12'h400;
    localparam logic [11:0] ER  = 12'h200;
    localparam logic [11:0] PD  = 12'h100;
    localparam logic [11:0] HZ  = 12'h080;
    localparam logic [11:0] BR  = 12'h040;
    localparam logic [11:0] JAL = 12'h020;
    localparam logic [11:0] JR  = 12'h010;
    localparam logic [11:0] J   = 12'h008;
    localparam logic [11:0] MS  = 12'h004;
    localparam logic [11:0] MD  = 12'h002;
    localparam logic [11:0] MU  = 12'h001;
    localparam logic [11:0] IDLE = 12'h000;

    typedef struct {
        string       nm;
        logic [11:0] exp;
    } sb_t;

    sb_t sb[$];
    int  n_vec = 0;
    int  n_err = 0;

    // Expected bundle: {en, req, op[2:0], stall_FD, flush_E, flush_all, busy, ack, state[1:0]}
    function automatic logic [11:0] ev(input logic en, input logic req, input logic [2:0] op,
                                       input logic sfd, input logic fle, input logic fla,
                                       input logic busy, input logic ack, input logic [1:0] st);
        return {en, req, op, sfd, fle, fla, busy, ack, st};
    endfunction

    function automatic logic [11:0] run(input logic [2:0] op, input logic [1:0] st);
        return ev(1'b1, 1'b0, op, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, st);
    endfunction

    function automatic logic [11:0] stl(input logic busy, input logic [1:0] st);
        return ev(1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, busy, 1'b0, st);
    endfunction

    function automatic logic [11:0] bsy(input logic [1:0] st);
        return ev(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, st);
    endfunction

    task automatic vec(input string nm, input logic [11:0] in, input logic [11:0] exp);
        sb_t e;
        @(posedge clk);
        #1;
        {reset, exc_req, eret_D, epc_wr_pend, haz_stall, br_D, jal_D, jr_D, j_D,
         md_start, md_is_div, md_use_D} = in;
        e.nm  = nm;
        e.exp = exp;
        sb.push_back(e);
    endtask

    // Monitor: every cycle with a pending vector is checked mid-cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            sb_t         e;
            logic [11:0] got;
            e   = sb.pop_front();
            got = {npc_en, npc_req, npc_op, stall_FD, flush_E, flush_all, md_busy, exc_ack, state};
            n_vec++;
            if (got !== e.exp) begin
                n_err++;
                $display("FAIL %s: got en/req/op/sfd/fle/fla/busy/ack/st=%b required %b",
                         e.nm, got, e.exp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        {reset, exc_req, eret_D, epc_wr_pend, haz_stall, br_D, jal_D, jr_D, j_D,
         md_start, md_is_div, md_use_D} = R;

        vec("reset",        R,    run(3'd0, 2'd0));
        for (int i = 0; i < 3; i++)
            vec("idle",     IDLE, run(3'd0, 2'd0));

        vec("jr_and_br",    JR | BR,       run(3'd3, 2'd0));
        vec("jal",          JAL,           run(3'd2, 2'd0));
        vec("j",            J,             run(3'd4, 2'd0));
        vec("br",           BR,            run(3'd1, 2'd0));
        vec("jal_j_br",     JAL | J | BR,  run(3'd2, 2'd0));

        vec("haz_enter",    HZ,            stl(1'b0, 2'd0));
        vec("haz_hold",     HZ,            stl(1'b0, 2'd1));
        vec("haz_exit_jal", JAL,           run(3'd2, 2'd1));
        vec("haz_after",    IDLE,          run(3'd0, 2'd0));

        vec("eret_pend",    ER | PD,       stl(1'b0, 2'd0));
        vec("eret_wait",    ER | PD,       stl(1'b0, 2'd2));
        vec("eret_release", IDLE,          run(3'd5, 2'd2));
        vec("eret_after",   IDLE,          run(3'd0, 2'd0));
        vec("eret_direct",  ER,            run(3'd5, 2'd0));

        vec("exc_req",      EX | HZ | JAL, ev(1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0));
        vec("exc_state",    EX | HZ,       ev(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3));
        vec("exc_after",    IDLE,          run(3'd0, 2'd0));

        vec("rst_haz_pre",  HZ,            stl(1'b0, 2'd0));
        vec("rst_haz",      R | HZ,        run(3'd0, 2'd1));
        vec("rst_haz_post", IDLE,          run(3'd0, 2'd0));
        vec("rst_eret_pre", ER | PD,       stl(1'b0, 2'd0));
        vec("rst_eret",     R | ER | PD,   run(3'd0, 2'd2));
        vec("rst_eret_post", IDLE,         run(3'd0, 2'd0));

`ifdef FETCH_CTRL_MD_STALL_EN
        vec("mul_start",    MS,            run(3'd0, 2'd0));
        vec("mul_stall0",   MU,            stl(1'b1, 2'd0));
        for (int i = 0; i < 4; i++)
            vec("mul_stall",MU,            stl(1'b1, 2'd1));
        vec("mul_done",     MU,            run(3'd0, 2'd1));
        vec("mul_after",    IDLE,          run(3'd0, 2'd0));

        vec("div_start",    MS | MD,       run(3'd0, 2'd0));
        for (int i = 0; i < 4; i++)
            vec("div_count",IDLE,          bsy(2'd0));
        vec("div_reset",    R | MU,        bsy(2'd0));
        vec("div_rst_post", MU,            run(3'd0, 2'd0));

        vec("md_exc",       EX | MS,       ev(1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0));
        vec("md_exc_state", IDLE,          ev(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3));
        vec("md_exc_noload", MU,           run(3'd0, 2'd0));

        vec("busy_start",   MS,            run(3'd0, 2'd0));
        vec("busy_restart", MS | MD,       bsy(2'd0));
        for (int i = 0; i < 4; i++)
            vec("busy_count",IDLE,         bsy(2'd0));
        vec("busy_done",    IDLE,          run(3'd0, 2'd0));

        vec("exc_keep_start", MS,          run(3'd0, 2'd0));
        vec("exc_keep_req", EX,            ev(1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0));
        vec("exc_keep_ack", IDLE,          ev(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd3));
        for (int i = 0; i < 3; i++)
            vec("exc_keep_cnt", IDLE,      bsy(2'd0));
        vec("exc_keep_done", IDLE,         run(3'd0, 2'd0));
`else
        vec("nomd_start",   MS,            run(3'd0, 2'd0));
        vec("nomd_use",     MU,            run(3'd0, 2'd0));
        vec("nomd_div_use", MS | MD | MU,  run(3'd0, 2'd0));
        vec("nomd_use2",    MU,            run(3'd0, 2'd0));
        vec("nomd_jr",      MU | JR,       run(3'd3, 2'd0));
`endif

        @(posedge clk);
        @(posedge clk);
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
